// File: rtl/sprite_pkg.sv
// Shared types and the fixed colour palette for the sprite layer.
// Contents:
//   pal_idx_t  4-bit palette index as stored in the sprite ROM
//   rgb444_t   packed 4:4:4 colour triple
//   SCREEN_W / SCREEN_H  visible raster size
//   palette()  maps a palette index to its RGB444 colour
package sprite_pkg;

  typedef logic [3:0] pal_idx_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  function automatic rgb444_t palette(input pal_idx_t idx);
    rgb444_t c;
    case (idx)
      4'h0: c = rgb444_t'(12'h000);
      4'h1: c = rgb444_t'(12'hF00);
      4'h2: c = rgb444_t'(12'h0F0);
      4'h3: c = rgb444_t'(12'h00F);
      4'h4: c = rgb444_t'(12'hFF0);
      4'h5: c = rgb444_t'(12'h0FF);
      4'h6: c = rgb444_t'(12'hF0F);
      4'h7: c = rgb444_t'(12'hFFF);
      4'h8: c = rgb444_t'(12'h888);
      4'h9: c = rgb444_t'(12'h800);
      4'hA: c = rgb444_t'(12'h080);
      4'hB: c = rgb444_t'(12'h008);
      4'hC: c = rgb444_t'(12'hF80);
      4'hD: c = rgb444_t'(12'h8F0);
      4'hE: c = rgb444_t'(12'h08F);
      default: c = rgb444_t'(12'h444);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_layer_renderer_if.sv
// Pixel-stream bundle between the VGA timing/mixer side and a sprite layer.
//   DrawX, DrawY  current pixel column/row (10 bits each)
//   blank         1 = active video
//   red/green/blue  layer colour, 4 bits each
//   pix_hit       1 = opaque sprite pixel at this position
// master: timing/mixer side (drives coordinates, receives colour)
// slave : sprite layer (receives coordinates, drives colour)
interface sprite_layer_renderer_if;

  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       pix_hit;

  modport master (
    output DrawX, DrawY, blank,
    input  red, green, blue, pix_hit
  );

  modport slave (
    input  DrawX, DrawY, blank,
    output red, green, blue, pix_hit
  );

endinterface

// File: rtl/sprite_frame_rom.sv
// Synchronous-read sprite texel ROM, one-cycle latency.
//   clock    read clock
//   address  texel address (frame-major, then row-major)
//   q        palette index registered from mem[address]
// The array is loaded externally; ROM_FILE is kept for port/parameter compatibility.
module sprite_frame_rom
  import sprite_pkg::*;
#(
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned AW       = 12,
  parameter string       ROM_FILE = "sprite.mem"
) (
  input  logic          clock,
  input  logic [AW-1:0] address,
  output pal_idx_t      q
);

  pal_idx_t mem [DEPTH];

  always_ff @(posedge clock) begin
    q <= mem[address];
  end

endmodule

// File: rtl/sprite_layer_renderer.sv
// Animated, integer-scaled sprite layer for the 640x480 VGA pipeline.
// Ports:
//   vga_clk, reset   pixel clock, synchronous active-high reset
//   frame_tick       one-cycle pulse at start of vertical blanking
//   anim_en          1 = animation advances on frame_tick
//   pos_x, pos_y     requested sprite top-left, latched on frame_tick
//   mirror_x         (SPRITE_MIRROR_EN only) horizontal flip, latched on frame_tick
//   vid              pixel stream (slave): DrawX/DrawY/blank in,
//                    red/green/blue/pix_hit out, 2-cycle latency
// Build option: define SPRITE_MIRROR_EN to add the mirror_x input.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned FRAME_HOLD = 8,
  parameter int unsigned TRANSP_IDX = 0,
  parameter string       ROM_FILE   = "sprite.mem"
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       anim_en,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
`ifdef SPRITE_MIRROR_EN
  input  logic       mirror_x,
`endif
  sprite_layer_renderer_if.slave vid
);

  localparam int unsigned DEPTH = NUM_FRAMES * SPR_W * SPR_H;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LXW   = $clog2(SPR_W);
  localparam int unsigned LYW   = $clog2(SPR_H);
  localparam int unsigned FW    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned HW    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int unsigned WIN_W = SPR_W << SCALE_LOG2;
  localparam int unsigned WIN_H = SPR_H << SCALE_LOG2;

  // ---------------------------------------------------------------
  // Per-frame state: latched position, animation counters
  // ---------------------------------------------------------------
  logic [9:0]    lpos_x_q, lpos_x_d;
  logic [9:0]    lpos_y_q, lpos_y_d;
  logic [FW-1:0] frame_q,  frame_d;
  logic [HW-1:0] hold_q,   hold_d;

  always_comb begin
    lpos_x_d = lpos_x_q;
    lpos_y_d = lpos_y_q;
    frame_d  = frame_q;
    hold_d   = hold_q;
    if (frame_tick) begin
      lpos_x_d = pos_x;
      lpos_y_d = pos_y;
      if (anim_en) begin
        if (hold_q == HW'(FRAME_HOLD - 1)) begin
          hold_d  = '0;
          frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      lpos_x_q <= '0;
      lpos_y_q <= '0;
      frame_q  <= '0;
      hold_q   <= '0;
    end else begin
      lpos_x_q <= lpos_x_d;
      lpos_y_q <= lpos_y_d;
      frame_q  <= frame_d;
      hold_q   <= hold_d;
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic mirror_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      mirror_q <= 1'b0;
    end else if (frame_tick) begin
      mirror_q <= mirror_x;
    end
  end
`endif

  // ---------------------------------------------------------------
  // S0: window test and ROM address
  // ---------------------------------------------------------------
  logic [10:0]    dx, dy;
  logic           in_win;
  logic [LXW-1:0] lx_raw, lx;
  logic [LYW-1:0] ly;
  logic [AW-1:0]  rom_addr;

  always_comb begin
    // 11-bit differences; bit 10 set means the pixel is left of/above the sprite
    dx     = {1'b0, vid.DrawX} - {1'b0, lpos_x_q};
    dy     = {1'b0, vid.DrawY} - {1'b0, lpos_y_q};
    in_win = ~dx[10] & ~dy[10] & (dx < 11'(WIN_W)) & (dy < 11'(WIN_H));
    lx_raw = LXW'(dx[9:0] >> SCALE_LOG2);
    ly     = LYW'(dy[9:0] >> SCALE_LOG2);
`ifdef SPRITE_MIRROR_EN
    // SPR_W is a power of two, so SPR_W-1-lx is the bitwise complement
    lx     = mirror_q ? ~lx_raw : lx_raw;
`else
    lx     = lx_raw;
`endif
    // Power-of-two sprite dimensions make frame*W*H + ly*W + lx a plain concatenation
    rom_addr = AW'({frame_q, ly, lx});
  end

  // ---------------------------------------------------------------
  // S1: ROM read; window/blank travel with the ROM's address register
  // ---------------------------------------------------------------
  pal_idx_t rom_idx;
  logic     in_win_q;
  logic     blank_q;

  sprite_frame_rom #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ROM_FILE (ROM_FILE)
  ) u_rom (
    .clock   (vga_clk),
    .address (rom_addr),
    .q       (rom_idx)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      in_win_q <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      in_win_q <= in_win;
      blank_q  <= vid.blank;
    end
  end

  // ---------------------------------------------------------------
  // S2: palette lookup and output register
  // ---------------------------------------------------------------
  rgb444_t texel_rgb;
  logic    hit;
  rgb444_t rgb_q;
  logic    hit_q;

  always_comb begin
    texel_rgb = palette(rom_idx);
    hit       = in_win_q & blank_q & (rom_idx != pal_idx_t'(TRANSP_IDX));
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rgb_q <= '0;
      hit_q <= 1'b0;
    end else begin
      rgb_q <= hit ? texel_rgb : '0;
      hit_q <= hit;
    end
  end

  assign vid.red     = rgb_q.r;
  assign vid.green   = rgb_q.g;
  assign vid.blue    = rgb_q.b;
  assign vid.pix_hit = hit_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench for sprite_layer_renderer. Two instances share all
// stimulus: u0 at scale 1x, u1 at scale 2x; both use FRAME_HOLD=2,
// NUM_FRAMES=4. ROM contents are loaded directly into each instance.
// Observed value format: {pix_hit, red, green, blue} (13 bits).
module tb_sprite_layer_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       frame_tick;
  logic       anim_en;
  logic [9:0] pos_x;
  logic [9:0] pos_y;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  sprite_layer_renderer_if vif0 ();
  sprite_layer_renderer_if vif1 ();

  sprite_layer_renderer #(
    .SPR_W(32), .SPR_H(32), .NUM_FRAMES(4), .SCALE_LOG2(0),
    .FRAME_HOLD(2), .TRANSP_IDX(0), .ROM_FILE("")
  ) u0 (
    .vga_clk    (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .anim_en    (anim_en),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
`ifdef SPRITE_MIRROR_EN
    .mirror_x   (1'b0),
`endif
    .vid        (vif0)
  );

  sprite_layer_renderer #(
    .SPR_W(32), .SPR_H(32), .NUM_FRAMES(4), .SCALE_LOG2(1),
    .FRAME_HOLD(2), .TRANSP_IDX(0), .ROM_FILE("")
  ) u1 (
    .vga_clk    (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .anim_en    (anim_en),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
`ifdef SPRITE_MIRROR_EN
    .mirror_x   (1'b0),
`endif
    .vid        (vif1)
  );

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] out0();
    return {vif0.pix_hit, vif0.red, vif0.green, vif0.blue};
  endfunction

  function automatic logic [12:0] out1();
    return {vif1.pix_hit, vif1.red, vif1.green, vif1.blue};
  endfunction

  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic b);
    vif0.DrawX = x; vif0.DrawY = y; vif0.blank = b;
    vif1.DrawX = x; vif1.DrawY = y; vif1.blank = b;
  endtask

  // Present one pixel for exactly one cycle, then a blanked pixel, and
  // sample right after the second rising edge (2-cycle latency).
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b);
    @(negedge clk);
    drive(x, y, b);
    @(negedge clk);
    drive(10'd0, 10'd0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic rom_put(input int unsigned a, input logic [3:0] v);
    u0.u_rom.mem[a] = v;
    u1.u_rom.mem[a] = v;
  endtask

  // frame-index sequence 1..8 ticks after reset-state frame 0, seen as texel (0,0)
  logic [12:0] exp_anim [8] = '{13'h1F00, 13'h10F0, 13'h10F0, 13'h100F,
                                13'h100F, 13'h1FF0, 13'h1FF0, 13'h1F00};

  initial begin
    reset = 1'b1; frame_tick = 1'b0; anim_en = 1'b0;
    pos_x = '0; pos_y = '0;
    drive(10'd0, 10'd0, 1'b0);

    for (int unsigned i = 0; i < 4096; i++) rom_put(i, 4'h8);
    rom_put(0,    4'h1);   // frame 0 texel (0,0)
    rom_put(1,    4'h9);   // frame 0 texel lx=1
    rom_put(2,    4'h0);   // frame 0 texel lx=2, transparent
    rom_put(19,   4'hD);   // frame 0 texel lx=19
    rom_put(32,   4'hA);   // frame 0 texel ly=1
    rom_put(1024, 4'h2);   // frame 1 texel (0,0)
    rom_put(2048, 4'h3);   // frame 2 texel (0,0)
    rom_put(3072, 4'h4);   // frame 3 texel (0,0)

    // Reset state
    drive(10'd0, 10'd0, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_state0", out0(), 13'h0000);
    check("reset_state1", out1(), 13'h0000);
    drive(10'd0, 10'd0, 1'b0);

    // Basic window at (100,50), scale 1x
    pos_x = 10'd100; pos_y = 10'd50;
    tick();
    pix(10'd100, 10'd50, 1'b1); check("origin",      out0(), 13'h1F00);
    pix(10'd99,  10'd50, 1'b1); check("left_out",    out0(), 13'h0000);
    pix(10'd101, 10'd50, 1'b1); check("lx1",         out0(), 13'h1800);
    pix(10'd102, 10'd50, 1'b1); check("transparent", out0(), 13'h0000);
    pix(10'd100, 10'd51, 1'b1); check("ly1",         out0(), 13'h1080);
    pix(10'd100, 10'd50, 1'b0); check("blanked",     out0(), 13'h0000);
    pix(10'd131, 10'd50, 1'b1); check("right_edge",  out0(), 13'h1888);
    pix(10'd132, 10'd50, 1'b1); check("right_out",   out0(), 13'h0000);
    pix(10'd100, 10'd81, 1'b1); check("bottom_edge", out0(), 13'h1888);
    pix(10'd100, 10'd82, 1'b1); check("bottom_out",  out0(), 13'h0000);

    // Scaling at (0,0)
    pos_x = 10'd0; pos_y = 10'd0;
    tick();
    pix(10'd0,  10'd0,  1'b1); check("s2_x0",     out1(), 13'h1F00);
    pix(10'd1,  10'd0,  1'b1); check("s2_x1",     out1(), 13'h1F00);
                               check("s1_x1",     out0(), 13'h1800);
    pix(10'd2,  10'd0,  1'b1); check("s2_x2",     out1(), 13'h1800);
    pix(10'd4,  10'd0,  1'b1); check("s2_transp", out1(), 13'h0000);
    pix(10'd63, 10'd0,  1'b1); check("s2_x63",    out1(), 13'h1888);
    pix(10'd64, 10'd0,  1'b1); check("s2_x64",    out1(), 13'h0000);
                               check("s1_x64",    out0(), 13'h0000);
    pix(10'd0,  10'd2,  1'b1); check("s2_y2",     out1(), 13'h1080);
    pix(10'd0,  10'd63, 1'b1); check("s2_y63",    out1(), 13'h1888);
    pix(10'd0,  10'd64, 1'b1); check("s2_y64",    out1(), 13'h0000);

    // Animation
    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      pix(10'd0, 10'd0, 1'b1);
      check($sformatf("anim%0d", i + 1), out0(), exp_anim[i]);
    end
    tick();
    tick();
    pix(10'd0, 10'd0, 1'b1); check("anim_f1", out0(), 13'h10F0);
    anim_en = 1'b0;
    repeat (3) tick();
    pix(10'd0, 10'd0, 1'b1); check("freeze", out0(), 13'h10F0);
    anim_en = 1'b1;
    tick();
    pix(10'd0, 10'd0, 1'b1); check("resume_hold", out0(), 13'h10F0);
    tick();
    pix(10'd0, 10'd0, 1'b1); check("resume_f2",   out0(), 13'h100F);
    anim_en = 1'b0;

    // Reset mid-line flushes pipeline and frame index
    @(negedge clk);
    drive(10'd0, 10'd0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(posedge clk); #1;
    check("rst_hold", out0(), 13'h0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_after", out0(), 13'h0000);
    tick();
    pix(10'd0, 10'd0, 1'b1); check("rst_frame0", out0(), 13'h1F00);

    // Right-edge clipping and frame-synchronous position
    pos_x = 10'd620; pos_y = 10'd0;
    tick();
    pix(10'd620, 10'd0, 1'b1); check("clip_620", out0(), 13'h1F00);
    pix(10'd639, 10'd0, 1'b1); check("clip_639", out0(), 13'h18F0);
    pix(10'd619, 10'd0, 1'b1); check("clip_619", out0(), 13'h0000);
    pix(10'd0,   10'd0, 1'b1); check("nowrap_0", out0(), 13'h0000);
    pix(10'd11,  10'd0, 1'b1); check("nowrap_11", out0(), 13'h0000);
    pos_x = 10'd100;
    pix(10'd620, 10'd0, 1'b1); check("midframe_old", out0(), 13'h1F00);
    pix(10'd100, 10'd0, 1'b1); check("midframe_new", out0(), 13'h0000);
    tick();
    pix(10'd100, 10'd0, 1'b1); check("nextframe_new", out0(), 13'h1F00);
    pix(10'd620, 10'd0, 1'b1); check("nextframe_old", out0(), 13'h0000);

    // Off-screen position
    pos_x = 10'd640; pos_y = 10'd0;
    tick();
    pix(10'd639, 10'd0, 1'b1); check("offscr_639", out0(), 13'h0000);
    pix(10'd0,   10'd0, 1'b1); check("offscr_0",   out0(), 13'h0000);
    pos_x = 10'd0; pos_y = 10'd480;
    tick();
    pix(10'd0, 10'd479, 1'b1); check("offscr_y", out0(), 13'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
